// File: rtl/crc32_rx_check.sv
// Receive-side CRC-32 checker: serialises each accepted nibble MSB-first through
// a 32-bit LFSR (init 0, no reflection, no final XOR) and reports the residue.
module crc32_rx_check #(
  parameter logic [31:0] CRC_POLY    = 32'h04C11DB7,
  parameter int          MAX_NIBBLES = 1024,
  parameter int          MIN_NIBBLES = 9
) (
  input  logic        clk_100Mz,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic [3:0]  DATA,
  output logic        done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic [31:0] residue,
  output logic [10:0] nib_cnt,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESULT = 2'd3;

  localparam logic [10:0] MIN_CNT = 11'(MIN_NIBBLES);
  localparam logic [10:0] MAX_CNT = 11'(MAX_NIBBLES);
  localparam logic [10:0] SAT_CNT = 11'(MAX_NIBBLES + 1);

  // Handshake: a nibble transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready depends only on state, never on in_valid.
  logic [1:0]  state;
  logic [31:0] lfsr;
  logic [3:0]  nib_sh;
  logic [1:0]  bit_cnt;
  logic        eof_l;
  logic        len_bad;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic b);
    logic fb;
    fb = s[31] ^ b;
    return {s[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
  endfunction

  assign in_ready  = (state == IDLE) || (state == WAIT);
  assign len_bad   = (nib_cnt < MIN_CNT) || (nib_cnt > MAX_CNT);
  assign dbg_state = state;

  always_ff @(posedge clk_100Mz or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lfsr    <= 32'h0;
      nib_sh  <= 4'h0;
      bit_cnt <= 2'd0;
      eof_l   <= 1'b0;
      done    <= 1'b0;
      crc_ok  <= 1'b0;
      crc_err <= 1'b0;
      len_err <= 1'b0;
      residue <= 32'h0;
      nib_cnt <= 11'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, WAIT: begin
          if (in_valid) begin
            // A sof restarts the frame from either state; a non-sof nibble
            // only continues a frame already in progress.
            if (in_sof) begin
              lfsr    <= 32'h0;
              crc_ok  <= 1'b0;
              crc_err <= 1'b0;
              len_err <= 1'b0;
              nib_cnt <= 11'd1;
              nib_sh  <= DATA;
              eof_l   <= in_eof;
              bit_cnt <= 2'd0;
              state   <= SHIFT;
            end else if (state == WAIT) begin
              if (nib_cnt != SAT_CNT) nib_cnt <= nib_cnt + 11'd1;
              nib_sh  <= DATA;
              eof_l   <= in_eof;
              bit_cnt <= 2'd0;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          lfsr    <= lfsr_step(lfsr, nib_sh[3]);
          nib_sh  <= {nib_sh[2:0], 1'b0};
          bit_cnt <= bit_cnt + 2'd1;
          if (bit_cnt == 2'd3) state <= eof_l ? RESULT : WAIT;
        end
        RESULT: begin
          done    <= 1'b1;
          residue <= lfsr;
          len_err <= len_bad;
          crc_ok  <= (lfsr == 32'h0) && !len_bad;
          crc_err <= !((lfsr == 32'h0) && !len_bad);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_rx_check.sv
// Bench for crc32_rx_check: directed frames, expected results queued at issue
// time and popped by a monitor on each done pulse.
module tb_crc32_rx_check;

  logic        clk_100Mz = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic        in_eof;
  logic [3:0]  DATA;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic        len_err;
  logic [31:0] residue;
  logic [10:0] nib_cnt;
  logic [1:0]  dbg_state;

  always #5 clk_100Mz = ~clk_100Mz;

  crc32_rx_check dut (
    .clk_100Mz (clk_100Mz),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_eof    (in_eof),
    .DATA      (DATA),
    .done      (done),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .len_err   (len_err),
    .residue   (residue),
    .nib_cnt   (nib_cnt),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int eof_cyc  = 0;
  int n_done   = 0;
  int n_exp    = 0;
  logic [45:0] exp_q[$];
  logic [3:0]  good_frame [26];

  always @(posedge clk_100Mz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [45:0] act, input logic [45:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Packed as {nib_cnt, len_err, crc_err, crc_ok, residue}
  task automatic push_exp(input logic [10:0] cnt, input logic le, input logic ce,
                          input logic ok, input logic [31:0] res);
    exp_q.push_back({cnt, le, ce, ok, res});
    n_exp++;
  endtask

  always @(negedge clk_100Mz) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        check("result", {nib_cnt, len_err, crc_err, crc_ok, residue}, exp_q.pop_front());
        check("done_latency", 46'(cyc - eof_cyc), 46'd5);
      end
    end
  end

  // Called and returns at a falling edge; chk also verifies how long in_ready stays low.
  task automatic send_nib(input logic [3:0] d, input logic sof, input logic eof, input logic chk);
    int w;
    int busy;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk_100Mz);
      w++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    in_valid = 1'b1;
    DATA     = d;
    in_sof   = sof;
    in_eof   = eof;
    @(posedge clk_100Mz);
    @(negedge clk_100Mz);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    if (eof) eof_cyc = cyc;
    if (chk) begin
      busy = 0;
      while (!in_ready && busy < 20) begin
        @(negedge clk_100Mz);
        busy++;
      end
      check("ready_low_cycles", 46'(busy), eof ? 46'd5 : 46'd4);
    end
  endtask

  task automatic send_good(input logic corrupt);
    logic [3:0] d;
    for (int i = 0; i < 26; i++) begin
      d = good_frame[i];
      if (corrupt && i == 25) d = d ^ 4'h1;
      send_nib(d, i == 0, i == 25, 1'b1);
    end
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_nib(4'h0, i == 0, i == n - 1, 1'b1);
  endtask

  initial begin
    good_frame = '{4'h3, 4'h1, 4'h3, 4'h2, 4'h3, 4'h3, 4'h3, 4'h4, 4'h3, 4'h5,
                   4'h3, 4'h6, 4'h3, 4'h7, 4'h3, 4'h8, 4'h3, 4'h9,
                   4'h8, 4'h9, 4'hA, 4'h1, 4'h8, 4'h9, 4'h7, 4'hF};
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; DATA = 4'h0;
    #1;
    check("reset_outputs", {in_ready, done, crc_ok, crc_err, len_err, residue, nib_cnt},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 11'd0});
    @(negedge clk_100Mz);
    @(negedge clk_100Mz);
    rst = 1'b0;

    // Nibble without sof in IDLE is dropped
    in_valid = 1'b1; in_sof = 1'b0; DATA = 4'h5;
    @(posedge clk_100Mz);
    @(negedge clk_100Mz);
    in_valid = 1'b0;
    check("drop_no_sof", {in_ready, dbg_state, nib_cnt}, {1'b1, 2'd0, 11'd0});

    // "123456789" with its CRC appended
    push_exp(11'd26, 1'b0, 1'b0, 1'b1, 32'h0);
    send_good(1'b0);

    // Last CRC bit flipped: residue becomes x^32 mod G
    push_exp(11'd26, 1'b0, 1'b1, 1'b0, 32'h04C11DB7);
    send_good(1'b1);

    // Minimum-length all-zero frame
    push_exp(11'd9, 1'b0, 1'b0, 1'b1, 32'h0);
    send_zeros(9);

    // Single nibble with sof and eof
    push_exp(11'd1, 1'b1, 1'b1, 1'b0, 32'h0);
    send_nib(4'h0, 1'b1, 1'b1, 1'b1);

    // Back-to-back: good frame then an immediate sof; flags clear on accept
    push_exp(11'd26, 1'b0, 1'b0, 1'b1, 32'h0);
    send_good(1'b0);
    push_exp(11'd26, 1'b0, 1'b1, 1'b0, 32'h04C11DB7);
    send_nib(good_frame[0], 1'b1, 1'b0, 1'b0);
    check("flags_clear_on_sof", {crc_ok, crc_err, len_err, nib_cnt}, {1'b0, 1'b0, 1'b0, 11'd1});
    for (int i = 1; i < 26; i++)
      send_nib((i == 25) ? (good_frame[i] ^ 4'h1) : good_frame[i], 1'b0, i == 25, 1'b1);

    // Sof reissued after 5 nibbles abandons the partial frame silently
    for (int i = 0; i < 5; i++) send_nib(good_frame[i], i == 0, 1'b0, 1'b1);
    push_exp(11'd26, 1'b0, 1'b0, 1'b1, 32'h0);
    send_good(1'b0);

    // Reset while nibble 10 is shifting
    for (int i = 0; i < 9; i++) send_nib(good_frame[i], i == 0, 1'b0, 1'b1);
    send_nib(good_frame[9], 1'b0, 1'b0, 1'b0);
    check("in_shift_before_rst", 46'(dbg_state), 46'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {in_ready, done, crc_ok, crc_err, len_err, residue, nib_cnt},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 11'd0});
    @(negedge clk_100Mz);
    rst = 1'b0;
    repeat (8) @(negedge clk_100Mz);
    push_exp(11'd26, 1'b0, 1'b0, 1'b1, 32'h0);
    send_good(1'b0);

    // Oversized frame: count saturates, length error reported
    push_exp(11'd1025, 1'b1, 1'b1, 1'b0, 32'h0);
    send_zeros(1030);

    repeat (10) @(negedge clk_100Mz);
    check("done_count", 46'(n_done), 46'(n_exp));
    check("queue_empty", 46'(exp_q.size()), 46'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
